// File: rtl/frankie.sv
// Relatively-prime finder: io_out = smallest m >= 2 with gcd(io_in, m) == 1.
// Each candidate m runs a subtractive GCD against the latched operand n.
//
// state | meaning
// IDLE  | waiting for a nonzero operand; io_out holds the last result
// INIT  | load GCD operands a = n, b = m
// GCD   | one subtraction per cycle until a == b
// CHECK | a is the gcd; accept m if it is 1, otherwise try m + 1
// DONE  | result valid; wait for io_in to return to 0
module frankie (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] io_in,
  output logic [15:0] io_out
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    GCD   = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state;
  logic [15:0] n;
  logic [15:0] m;
  logic [15:0] a;
  logic [15:0] b;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      io_out <= 16'd0;
      n      <= 16'd0;
      m      <= 16'd0;
      a      <= 16'd0;
      b      <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (io_in != 16'd0) begin
            n      <= io_in;
            m      <= 16'd2;
            io_out <= 16'd0;
            state  <= INIT;
          end
        end
        INIT: begin
          a     <= n;
          b     <= m;
          state <= GCD;
        end
        GCD: begin
          // n >= 1 and m >= 2 keep both operands nonzero, so this terminates
          if (a > b) begin
            a <= a - b;
          end else if (b > a) begin
            b <= b - a;
          end else begin
            state <= CHECK;
          end
        end
        CHECK: begin
          if (a == 16'd1) begin
            io_out <= m;
            state  <= DONE;
          end else begin
            m     <= m + 16'd1;
            state <= INIT;
          end
        end
        DONE: begin
          if (io_in == 16'd0) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frankie.sv
// Directed bench for frankie: hand-computed relprime results, exact latency
// for short cases, reset mid-computation, and io_in changes while busy.
module tb_frankie;

  localparam int WATCHDOG = 500000;

  logic        clock;
  logic        reset;
  logic [15:0] io_in;
  logic [15:0] io_out;

  int errors = 0;
  int checks = 0;

  frankie dut (
    .clock  (clock),
    .reset  (reset),
    .io_in  (io_in),
    .io_out (io_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Wait for the result; io_out may only ever be 0 or the final value meanwhile.
  task automatic wait_result(input string tag, input logic [15:0] exp);
    int  cyc;
    bit  bad;
    cyc = 0;
    bad = 1'b0;
    tick();
    while (io_out !== exp && cyc < WATCHDOG) begin
      if (io_out !== 16'd0) bad = 1'b1;
      tick();
      cyc++;
    end
    chk({tag, "_result"}, {16'd0, io_out}, {16'd0, exp});
    chk({tag, "_no_glitch"}, {31'd0, bad}, 32'd0);
  endtask

  // From IDLE: io_out stays 0 for lat-1 edges and shows the result on edge lat.
  task automatic exact_latency(input string tag, input logic [15:0] n,
                               input int lat, input logic [15:0] exp);
    io_in = n;
    repeat (lat - 1) tick();
    chk({tag, "_busy"}, {16'd0, io_out}, 32'd0);
    tick();
    chk({tag, "_at_latency"}, {16'd0, io_out}, {16'd0, exp});
  endtask

  initial begin
    bit bad;
    reset = 1'b1;
    io_in = 16'd0;
    repeat (5) tick();
    chk("reset_out", {16'd0, io_out}, 32'd0);
    reset = 1'b0;

    // 5040 = 2^4*3^2*5*7 -> 11; io_in removed while still busy
    io_in = 16'd5040;
    bad = 1'b0;
    repeat (25) begin
      tick();
      if (io_out !== 16'd0) bad = 1'b1;
    end
    chk("n5040_zero_while_busy", {31'd0, bad}, 32'd0);
    io_in = 16'd0;
    wait_result("n5040", 16'd11);
    repeat (5) tick();
    chk("n5040_hold_idle", {16'd0, io_out}, 32'd11);

    // Restart from IDLE clears io_out on the first edge
    io_in = 16'd30;
    tick();
    chk("n30_clear", {16'd0, io_out}, 32'd0);
    wait_result("n30", 16'd7);
    repeat (4) tick();
    chk("n30_hold_done", {16'd0, io_out}, 32'd7);

    io_in = 16'd0;
    tick();
    io_in = 16'd6;
    wait_result("n6", 16'd5);

    // In-flight io_in change to 6 must not affect the 30 computation
    io_in = 16'd0;
    tick();
    io_in = 16'd30;
    repeat (3) tick();
    io_in = 16'd6;
    wait_result("n30_ignore_change", 16'd7);
    repeat (5) tick();
    chk("n30_done_nonzero_in", {16'd0, io_out}, 32'd7);

    // n = 7: m = 2 needs 4 subtractions -> 1 + 4 + 3 = 8 edges
    io_in = 16'd0;
    tick();
    exact_latency("n7", 16'd7, 8, 16'd2);

    // n = 1: m = 2 needs 1 subtraction -> 1 + 1 + 3 = 5 edges
    io_in = 16'd0;
    tick();
    exact_latency("n1", 16'd1, 5, 16'd2);

    // 65535 = 3*5*17*257 is odd -> 2
    io_in = 16'd0;
    tick();
    io_in = 16'd65535;
    wait_result("n65535", 16'd2);

    // Reset mid-GCD
    io_in = 16'd0;
    tick();
    io_in = 16'd5040;
    repeat (20) tick();
    reset = 1'b1;
    io_in = 16'd0;
    tick();
    chk("midrun_reset_out", {16'd0, io_out}, 32'd0);
    reset = 1'b0;
    repeat (4) tick();
    chk("post_reset_idle", {16'd0, io_out}, 32'd0);
    io_in = 16'd6;
    wait_result("n6_after_reset", 16'd5);

    // Reset while in DONE
    reset = 1'b1;
    tick();
    chk("done_reset_out", {16'd0, io_out}, 32'd0);
    reset = 1'b0;
    io_in = 16'd0;
    tick();
    exact_latency("n7_after_reset", 16'd7, 8, 16'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
